// File: rtl/nap_protocol_sequencer.sv
// nap_protocol_sequencer: timed extraction-protocol controller for the five-lane reactor array.
// Ports: start/abort/pause control in; busy/done/aborted/step status out; ten valve lines and
//   three peristaltic pump lines out. Outputs are registered: one cycle from input to output.
// Lines are active-low (1 = pressurised = closed). No backpressure on the control interface.
// Optional build macro: SEQ_PAUSE_EN (pause input freezes the sequencer when defined).
module nap_protocol_sequencer #(
  parameter int CNT_W       = 16,
  parameter int LOAD_CYC    = 200,
  parameter int MIX_CYC     = 1000,
  parameter int TRAP_CYC    = 400,
  parameter int WASH_CYC    = 300,
  parameter int WASH_REPS   = 3,
  parameter int ELUTE_CYC   = 300,
  parameter int COLLECT_CYC = 200,
  parameter int PUMP_DIV    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       pause,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [2:0] step,
  output logic       lysis_ctl,
  output logic       wash_in_ctl,
  output logic       elute_ctl,
  output logic       vertical_ctl,
  output logic       horiz_ctl,
  output logic       loop_exit_ctl,
  output logic       bead_vtl_ctl,
  output logic       bead_trap_ctl,
  output logic       collection_ctl,
  output logic       waste_ctl,
  output logic       pump1,
  output logic       pump2,
  output logic       pump3
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_MIX = 3'd2, S_TRAP = 3'd3,
    S_WASH = 3'd4, S_ELUTE = 3'd5, S_COLLECT = 3'd6, S_END = 3'd7
  } state_t;

  // A zero-length step would never expire, so zero is promoted to one cycle.
  localparam logic [CNT_W-1:0] LOAD_LAST    = CNT_W'(((LOAD_CYC    == 0) ? 1 : LOAD_CYC)    - 1);
  localparam logic [CNT_W-1:0] MIX_LAST     = CNT_W'(((MIX_CYC     == 0) ? 1 : MIX_CYC)     - 1);
  localparam logic [CNT_W-1:0] TRAP_LAST    = CNT_W'(((TRAP_CYC    == 0) ? 1 : TRAP_CYC)    - 1);
  localparam logic [CNT_W-1:0] WASH_LAST    = CNT_W'(((WASH_CYC    == 0) ? 1 : WASH_CYC)    - 1);
  localparam logic [CNT_W-1:0] ELUTE_LAST   = CNT_W'(((ELUTE_CYC   == 0) ? 1 : ELUTE_CYC)   - 1);
  localparam logic [CNT_W-1:0] COLLECT_LAST = CNT_W'(((COLLECT_CYC == 0) ? 1 : COLLECT_CYC) - 1);
  localparam logic [CNT_W-1:0] PDIV_LAST    = CNT_W'(((PUMP_DIV    == 0) ? 1 : PUMP_DIV)    - 1);
  localparam logic [3:0]       REPS_N       = 4'((WASH_REPS == 0) ? 1 : WASH_REPS);

  // Valve vector order: lysis, wash_in, elute, vertical, horiz, loop_exit, bead_vtl, bead_trap,
  // collection, waste. A 0 bit opens that valve.
  function automatic logic [9:0] valves_for(input state_t s);
    case (s)
      S_LOAD:    valves_for = 10'b0110111111;
      S_MIX:     valves_for = 10'b1111011111;
      S_TRAP:    valves_for = 10'b1111101010;
      S_WASH:    valves_for = 10'b1010101010;
      S_ELUTE:   valves_for = 10'b1100101011;
      S_COLLECT: valves_for = 10'b1111101001;
      default:   valves_for = 10'b1111111111;
    endcase
  endfunction

  function automatic logic is_pump(input state_t s);
    return (s >= S_MIX) && (s <= S_COLLECT);
  endfunction

  // Six-phase peristaltic pattern {pump1,pump2,pump3}.
  function automatic logic [2:0] pump_pat(input logic [2:0] ph);
    case (ph)
      3'd0:    pump_pat = 3'b100;
      3'd1:    pump_pat = 3'b110;
      3'd2:    pump_pat = 3'b010;
      3'd3:    pump_pat = 3'b011;
      3'd4:    pump_pat = 3'b001;
      default: pump_pat = 3'b101;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d, pdiv_q, pdiv_d, step_last;
  logic [3:0]       wash_q, wash_d;
  logic [2:0]       phase_q, phase_d, pump_q, pump_d;
  logic [9:0]       valve_q, valve_d;
  logic             busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic             active, hold;

  assign active = (state_q != S_IDLE) && (state_q != S_END);

`ifdef SEQ_PAUSE_EN
  // Abort takes precedence over pause so a frozen run can still be abandoned.
  assign hold = pause && active && !abort;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign hold = 1'b0;
`endif

  always_comb begin
    case (state_q)
      S_MIX:     step_last = MIX_LAST;
      S_TRAP:    step_last = TRAP_LAST;
      S_WASH:    step_last = WASH_LAST;
      S_ELUTE:   step_last = ELUTE_LAST;
      S_COLLECT: step_last = COLLECT_LAST;
      default:   step_last = LOAD_LAST;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    wash_d    = wash_q;
    pdiv_d    = pdiv_q;
    phase_d   = phase_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    if (active && abort) begin
      state_d   = S_END;
      timer_d   = '0;
      aborted_d = 1'b1;
    end else if (!hold) begin
      case (state_q)
        S_IDLE: if (start) begin
          state_d = S_LOAD;
          timer_d = '0;
          wash_d  = '0;
        end
        S_END: state_d = S_IDLE;
        default: begin
          if (timer_q == step_last) begin
            timer_d = '0;
            case (state_q)
              S_LOAD:  state_d = S_MIX;
              S_MIX:   state_d = S_TRAP;
              S_TRAP:  state_d = S_WASH;
              S_WASH: begin
                // Staying in WASH keeps the same valve pattern, so passes join without a glitch.
                wash_d = wash_q + 4'd1;
                if (wash_d >= REPS_N) state_d = S_ELUTE;
              end
              S_ELUTE: state_d = S_COLLECT;
              default: begin
                state_d = S_END;
                done_d  = 1'b1;
              end
            endcase
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
      endcase
    end

    // Pump phase restarts on MIX entry and free-runs through the later pumping states.
    if (state_d == S_MIX && state_q != S_MIX) begin
      phase_d = '0;
      pdiv_d  = '0;
    end else if (!hold && is_pump(state_q) && is_pump(state_d)) begin
      if (pdiv_q == PDIV_LAST) begin
        pdiv_d  = '0;
        phase_d = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
      end else begin
        pdiv_d = pdiv_q + CNT_W'(1);
      end
    end

    valve_d = valves_for(state_d);
    pump_d  = is_pump(state_d) ? pump_pat(phase_d) : 3'b111;
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      wash_q    <= '0;
      pdiv_q    <= '0;
      phase_q   <= '0;
      valve_q   <= '1;
      pump_q    <= 3'b111;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      wash_q    <= wash_d;
      pdiv_q    <= pdiv_d;
      phase_q   <= phase_d;
      valve_q   <= valve_d;
      pump_q    <= pump_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign step    = state_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign {lysis_ctl, wash_in_ctl, elute_ctl, vertical_ctl, horiz_ctl,
          loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl, waste_ctl} = valve_q;
  assign {pump1, pump2, pump3} = pump_q;

endmodule

// File: tb/tb_nap_protocol_sequencer.sv
// Bench for nap_protocol_sequencer with default parameters: directed probe table,
// reset checks, full-run duration/pause checks and randomized runs against a timeline model.
module tb_nap_protocol_sequencer;

  logic clk = 1'b0;
  logic rst, start, abort, pause;
  logic busy, done, aborted;
  logic [2:0] step;
  logic lysis_ctl, wash_in_ctl, elute_ctl, vertical_ctl, horiz_ctl;
  logic loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl, waste_ctl;
  logic pump1, pump2, pump3;

  always #5 clk = ~clk;

  nap_protocol_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
    .busy(busy), .done(done), .aborted(aborted), .step(step),
    .lysis_ctl(lysis_ctl), .wash_in_ctl(wash_in_ctl), .elute_ctl(elute_ctl),
    .vertical_ctl(vertical_ctl), .horiz_ctl(horiz_ctl), .loop_exit_ctl(loop_exit_ctl),
    .bead_vtl_ctl(bead_vtl_ctl), .bead_trap_ctl(bead_trap_ctl),
    .collection_ctl(collection_ctl), .waste_ctl(waste_ctl),
    .pump1(pump1), .pump2(pump2), .pump3(pump3)
  );

  // Protocol timeline in cycles after the start edge.
  localparam int MIX_AT   = 200;
  localparam int TRAP_AT  = MIX_AT + 1000;
  localparam int WASH_AT  = TRAP_AT + 400;
  localparam int ELUTE_AT = WASH_AT + 3 * 300;
  localparam int COLL_AT  = ELUTE_AT + 300;
  localparam int END_AT   = COLL_AT + 200;
  localparam int PDIV     = 4;
`ifdef SEQ_PAUSE_EN
  localparam int PAUSE_EXT = 50;
`else
  localparam int PAUSE_EXT = 0;
`endif

  // Closed-valve masks {lysis,wash_in,elute,vertical,horiz,loop_exit,bead_vtl,bead_trap,collection,waste}.
  localparam logic [9:0] M_LOAD  = 10'b0110111111;
  localparam logic [9:0] M_MIX   = 10'b1111011111;
  localparam logic [9:0] M_TRAP  = 10'b1111101010;
  localparam logic [9:0] M_WASH  = 10'b1010101010;
  localparam logic [9:0] M_ELUTE = 10'b1100101011;
  localparam logic [9:0] M_COLL  = 10'b1111101001;
  localparam logic [9:0] M_ALL   = 10'b1111111111;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int          ab;
    int          probe;
    logic [18:0] exp;
    string       nm;
  } vec_t;
  vec_t vt [17];

  function automatic logic [18:0] mk(input bit b, input bit d, input bit a, input int st,
                                     input logic [9:0] v, input logic [2:0] p);
    return {b, d, a, 3'(st), v, p};
  endfunction

  localparam logic [18:0] RST_V = {3'b000, 3'd0, 10'b1111111111, 3'b111};

  function automatic logic [18:0] sample();
    return {busy, done, aborted, step, lysis_ctl, wash_in_ctl, elute_ctl, vertical_ctl,
            horiz_ctl, loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl, waste_ctl,
            pump1, pump2, pump3};
  endfunction

  function automatic logic [9:0] mask_of(input int st);
    case (st)
      1: return M_LOAD;
      2: return M_MIX;
      3: return M_TRAP;
      4: return M_WASH;
      5: return M_ELUTE;
      6: return M_COLL;
      default: return M_ALL;
    endcase
  endfunction

  function automatic logic [2:0] pat_of(input int ph);
    case (ph)
      0: return 3'b100;
      1: return 3'b110;
      2: return 3'b010;
      3: return 3'b011;
      4: return 3'b001;
      default: return 3'b101;
    endcase
  endfunction

  function automatic int norm_state(input int k);
    if (k < MIX_AT)   return 1;
    if (k < TRAP_AT)  return 2;
    if (k < WASH_AT)  return 3;
    if (k < ELUTE_AT) return 4;
    if (k < COLL_AT)  return 5;
    if (k < END_AT)   return 6;
    if (k == END_AT)  return 7;
    return 0;
  endfunction

  // Expected outputs k cycles after the start edge, given abort cycle and pause window.
  function automatic logic [18:0] exp_at(input int k, input int ab, input int p0, input int plen);
    int ke, st;
    bit abd;
    logic [2:0] pp;
    ke = k;
    abd = 1'b0;
`ifdef SEQ_PAUSE_EN
    if (plen > 0 && k > p0) ke = (k <= p0 + plen) ? p0 : k - plen;
`endif
    st = norm_state(ke);
    if (ab >= 0 && ab < END_AT && k > ab) begin
      st  = (k == ab + 1) ? 7 : 0;
      abd = (k == ab + 1);
    end
    pp = (st >= 2 && st <= 6) ? pat_of(((ke - MIX_AT) / PDIV) % 6) : 3'b111;
    return mk(st != 0, st == 7 && !abd, abd, st, mask_of(st), pp);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [18:0] got, input logic [18:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b required %b", nm, got, exp);
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", nm, got, exp);
  endtask

  // Starts a run from IDLE and steps to offset stop_k, comparing every cycle with the model.
  task automatic run(input int ab, input int p0, input int plen, input bit rnd, input int stop_k,
                     output logic [18:0] last, output int busy_n, output int done_n,
                     output int abrt_n);
    logic [18:0] got;
    int lim;
    busy_n = 0; done_n = 0; abrt_n = 0; last = '0;
    lim = (ab >= 0 && ab < 2990) ? ab : 2990;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= stop_k; k++) begin
      got = sample();
      chk($sformatf("model k=%0d ab=%0d", k, ab), got, exp_at(k, ab, p0, plen));
      busy_n += int'(busy);
      done_n += int'(done);
      abrt_n += int'(aborted);
      if (k == stop_k) begin
        last = got;
      end else begin
        abort = (k == ab);
        pause = (plen > 0 && k >= p0 && k < p0 + plen);
`ifndef SEQ_PAUSE_EN
        if (rnd) pause = 1'($urandom);
`endif
        start = (rnd && k <= lim) ? 1'($urandom) : 1'b0;
        tick();
      end
    end
    abort = 1'b0; pause = 1'b0; start = 1'b0;
  endtask

  task automatic set_row(input int i, input int ab, input int probe, input logic [18:0] e,
                         input string nm);
    vt[i].ab = ab; vt[i].probe = probe; vt[i].exp = e; vt[i].nm = nm;
  endtask

  initial begin
    logic [18:0] last;
    int b_n, d_n, a_n, ab, stop;

    set_row(0,  -1, 0,       mk(1,0,0,1,M_LOAD,3'b111),  "load_first");
    set_row(1,  -1, 199,     mk(1,0,0,1,M_LOAD,3'b111),  "load_last");
    set_row(2,  -1, 200,     mk(1,0,0,2,M_MIX,3'b100),   "mix_first");
    set_row(3,  -1, 203,     mk(1,0,0,2,M_MIX,3'b100),   "pump_hold4");
    set_row(4,  -1, 204,     mk(1,0,0,2,M_MIX,3'b110),   "pump_phase1");
    set_row(5,  -1, 223,     mk(1,0,0,2,M_MIX,3'b101),   "pump_phase5");
    set_row(6,  -1, 224,     mk(1,0,0,2,M_MIX,3'b100),   "pump_wrap");
    set_row(7,  -1, 1599,    mk(1,0,0,3,M_TRAP,3'b110),  "trap_last");
    set_row(8,  -1, 1600,    mk(1,0,0,4,M_WASH,3'b010),  "wash_first");
    set_row(9,  -1, 1900,    mk(1,0,0,4,M_WASH,3'b101),  "wash_pass2");
    set_row(10, -1, 2500,    mk(1,0,0,5,M_ELUTE,3'b101), "elute_first");
    set_row(11, -1, 3000,    mk(1,1,0,7,M_ALL,3'b111),   "end_done");
    set_row(12, -1, 3001,    mk(0,0,0,0,M_ALL,3'b111),   "idle_after_done");
    set_row(13, 2000, 2001,  mk(1,0,1,7,M_ALL,3'b111),   "abort_wash2_end");
    set_row(14, 2000, 2002,  mk(0,0,0,0,M_ALL,3'b111),   "abort_wash2_idle");
    set_row(15, 1599, 1600,  mk(1,0,1,7,M_ALL,3'b111),   "abort_vs_expiry");
    set_row(16, 3000, 3001,  mk(0,0,0,0,M_ALL,3'b111),   "abort_in_end_ignored");

    rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
    repeat (3) tick();
    chk("reset_state", sample(), RST_V);
    rst = 1'b0;
    repeat (6) tick();
    chk("idle_no_start", sample(), RST_V);

    for (int i = 0; i < 17; i++) begin
      run(vt[i].ab, -1, 0, 1'b0, vt[i].probe, last, b_n, d_n, a_n);
      chk(vt[i].nm, last, vt[i].exp);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_run", sample(), RST_V);
      tick();
      chk("rst_no_pulse", sample(), RST_V);
    end

    run(-1, -1, 0, 1'b1, END_AT + 4, last, b_n, d_n, a_n);
    chk_int("full_busy_cycles", b_n, 3001);
    chk_int("full_done_pulses", d_n, 1);
    chk_int("full_abort_pulses", a_n, 0);

    run(-1, 2600, 50, 1'b0, END_AT + 60, last, b_n, d_n, a_n);
    chk_int("pause_busy_cycles", b_n, 3001 + PAUSE_EXT);
    chk_int("pause_done_pulses", d_n, 1);

    for (int r = 0; r < 4; r++) begin
      ab = $urandom_range(0, 3100);
      stop = (ab < END_AT) ? ab + 3 : END_AT + 4;
      run(ab, -1, 0, 1'b1, stop, last, b_n, d_n, a_n);
      chk_int("rand_abort_pulses", a_n, (ab < END_AT) ? 1 : 0);
      chk_int("rand_done_pulses", d_n, (ab < END_AT) ? 0 : 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
